// File: rtl/rpn_stack_master.sv
// rpn_stack_master: postfix (RPN) integer evaluator that owns all traffic to an
// external LIFO stack. Operands are pushed, and each operator pops B then A,
// computes A op B and pushes the result. "=" pops the top word and presents it
// as the result.
//
// Optional build macro RPN_OVF_DETECT_EN: when defined, EXEC evaluates at full
// precision and raises error code 3 on signed overflow instead of wrapping.
//
// Handshakes: a token transfers on a rising edge where tok_valid && tok_ready,
// and a result transfers where res_valid && res_ready. A valid is held with
// stable data until its transfer, and a ready may depend combinationally on
// the current state only.
module rpn_stack_master #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PUSH_OPND = 4'd1,
    S_POP_B     = 4'd2,
    S_POP_A     = 4'd3,
    S_EXEC      = 4'd4,
    S_PUSH_R    = 4'd5,
    S_POP_R     = 4'd6,
    S_EMIT      = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_EQ  = 2'd3;

`ifdef RPN_OVF_DETECT_EN
  localparam int FW = 2 * WIDTH;
`else
  localparam int FW = WIDTH;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       code_q, code_d;

  logic signed [FW-1:0] a_x, b_x, full;

  // Operands widened to the evaluation width (sign-extended when checking overflow).
`ifdef RPN_OVF_DETECT_EN
  assign a_x = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_x = {{WIDTH{b_q[WIDTH-1]}}, b_q};
`else
  assign a_x = a_q;
  assign b_x = b_q;
`endif

  // Arithmetic unit: A is the deeper operand, so SUB yields A - B.
  always_comb begin
    full = '0;
    case (op_q)
      OP_ADD:  full = a_x + b_x;
      OP_SUB:  full = a_x - b_x;
      OP_MUL:  full = a_x * b_x;
      default: full = '0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      res_q   <= res_d;
      code_q  <= code_d;
    end
  end

  // Next-state, datapath updates and stack strobes.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    op_d      = op_q;
    res_d     = res_q;
    code_d    = code_q;
    tok_ready = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          if (tok_is_op) begin
            op_d    = tok_data[1:0];
            state_d = (tok_data[1:0] == OP_EQ) ? S_POP_R : S_POP_B;
          end else begin
            r_d     = tok_data;
            state_d = S_PUSH_OPND;
          end
        end
      end
      S_PUSH_OPND: begin
        if (stk_full) begin
          code_d  = 2'd2;
          state_d = S_ERR;
        end else begin
          stk_push = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_POP_B: begin
        if (stk_empty) begin
          code_d  = 2'd1;
          state_d = S_ERR;
        end else begin
          stk_pop = 1'b1;
          b_d     = stk_rdata;
          state_d = S_POP_A;
        end
      end
      S_POP_A: begin
        if (stk_empty) begin
          code_d  = 2'd1;
          state_d = S_ERR;
        end else begin
          stk_pop = 1'b1;
          a_d     = stk_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        r_d     = full[WIDTH-1:0];
        state_d = S_PUSH_R;
`ifdef RPN_OVF_DETECT_EN
        if (full != {{WIDTH{full[WIDTH-1]}}, full[WIDTH-1:0]}) begin
          code_d  = 2'd3;
          state_d = S_ERR;
        end
`endif
      end
      S_PUSH_R: begin
        // Two words were just popped, so the stack has room.
        stk_push = 1'b1;
        state_d  = S_IDLE;
      end
      S_POP_R: begin
        if (stk_empty) begin
          code_d  = 2'd1;
          state_d = S_ERR;
        end else begin
          stk_pop = 1'b1;
          res_d   = stk_rdata;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (res_ready) state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    // Nothing leaves the block while reset is held.
    if (rst) begin
      tok_ready = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
    end
  end

  assign stk_wdata = r_q;
  assign res_valid = (state_q == S_EMIT);
  assign res_data  = res_q;
  assign err       = (state_q == S_ERR);
  assign err_code  = code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_stack_master.sv
// Bench for rpn_stack_master: behavioural LIFO model, table of token
// sequences with hand-computed outcomes, and hand-written timing sequences.
module tb_rpn_stack_master;

  localparam int W = 8;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_EXEC = 4'd4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_op = 1'b0;
  logic [W-1:0] tok_data = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         err;
  logic [1:0]   err_code;
  logic         stk_push, stk_pop;
  logic [W-1:0] stk_wdata, stk_rdata;
  logic         stk_full, stk_empty;
  logic [3:0]   dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  rpn_stack_master #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .err_code(err_code),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .stk_full(stk_full), .stk_empty(stk_empty), .dbg_state(dbg_state)
  );

  // Behavioural LIFO with run-time depth.
  logic [W-1:0] mem [16];
  int cnt = 0;
  int depth = 8;
  assign stk_empty = (cnt == 0);
  assign stk_full  = (cnt >= depth);
  assign stk_rdata = (cnt > 0) ? mem[cnt-1] : '0;
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (stk_push && cnt < 16) begin
      mem[cnt] <= stk_wdata;
      cnt      <= cnt + 1;
    end else if (stk_pop && cnt > 0) cnt <= cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard of stack traffic (enabled for selected sequences).
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_pop_q[$];
  bit chk_sb = 1'b0;
  int pop_seen = 0;
  always @(negedge clk) begin
    if (stk_pop) pop_seen++;
    if (stk_push || stk_pop)
      chk("strobe_rule", {29'd0, stk_push && stk_pop, stk_pop && stk_empty, stk_push && stk_full}, 32'd0);
    if (chk_sb && stk_push) begin
      if (exp_q.size() == 0) chk("push_unexpected", 32'd1, 32'd0);
      else chk("push_data", stk_wdata, exp_q.pop_front());
    end
    if (chk_sb && stk_pop) begin
      if (exp_pop_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else chk("pop_data", stk_rdata, exp_pop_q.pop_front());
    end
  end

  // Driver tasks.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tok_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic op, input logic [W-1:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = op; tok_data = d;
    for (int i = 0; i < 20; i++) begin
      if (tok_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tok_valid = 1'b0;
  endtask

  task automatic wait_outcome();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid || err) break;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  typedef struct {
    int          ntok;
    logic [5:0]  is_op;
    logic [47:0] data;
    int          dep;
    logic        exp_res;
    logic [7:0]  exp_data;
    logic [1:0]  exp_code;
    int          exp_cnt;
  } vec_t;

  function automatic vec_t mk(int n, logic [5:0] ops,
                              logic [7:0] t0, logic [7:0] t1, logic [7:0] t2,
                              logic [7:0] t3, logic [7:0] t4, logic [7:0] t5,
                              int dp, logic r, logic [7:0] d, logic [1:0] c, int ec);
    vec_t v;
    v.ntok = n; v.is_op = ops; v.data = {t5, t4, t3, t2, t1, t0};
    v.dep = dp; v.exp_res = r; v.exp_data = d; v.exp_code = c; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic run_vec(input int k, input vec_t v);
    bit ok;
    depth = v.dep;
    do_reset();
    for (int i = 0; i < v.ntok; i++) begin
      send(v.is_op[i], v.data[i*8 +: 8], ok);
      if (!ok) break;
    end
    wait_outcome();
    chk($sformatf("v%0d_res_valid", k), res_valid, v.exp_res);
    if (v.exp_res) chk($sformatf("v%0d_res_data", k), res_data, v.exp_data);
    chk($sformatf("v%0d_err", k), err, v.exp_code != 2'd0);
    chk($sformatf("v%0d_err_code", k), err_code, v.exp_code);
    chk($sformatf("v%0d_stack_count", k), cnt, v.exp_cnt);
    if (res_valid) consume();
  endtask

  vec_t vecs[13];

  initial begin
    bit ok;
    // Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 EQ.
    vecs[0]  = mk(4, 6'b001100, 8'd3,   8'd4, 8'd0,  8'd3, 8'd0, 8'd0, 8, 1'b1, 8'h07, 2'd0, 0);
    vecs[1]  = mk(4, 6'b001100, 8'd5,   8'd7, 8'd1,  8'd3, 8'd0, 8'd0, 8, 1'b1, 8'hFE, 2'd0, 0);
`ifdef RPN_OVF_DETECT_EN
    vecs[2]  = mk(4, 6'b001100, 8'd100, 8'd2, 8'd2,  8'd3, 8'd0, 8'd0, 8, 1'b0, 8'h00, 2'd3, 0);
    vecs[7]  = mk(4, 6'b001100, 8'd127, 8'd1, 8'd0,  8'd3, 8'd0, 8'd0, 8, 1'b0, 8'h00, 2'd3, 0);
    vecs[10] = mk(4, 6'b001100, 8'h80,  8'd1, 8'd1,  8'd3, 8'd0, 8'd0, 8, 1'b0, 8'h00, 2'd3, 0);
`else
    vecs[2]  = mk(4, 6'b001100, 8'd100, 8'd2, 8'd2,  8'd3, 8'd0, 8'd0, 8, 1'b1, 8'hC8, 2'd0, 0);
    vecs[7]  = mk(4, 6'b001100, 8'd127, 8'd1, 8'd0,  8'd3, 8'd0, 8'd0, 8, 1'b1, 8'h80, 2'd0, 0);
    vecs[10] = mk(4, 6'b001100, 8'h80,  8'd1, 8'd1,  8'd3, 8'd0, 8'd0, 8, 1'b1, 8'h7F, 2'd0, 0);
`endif
    vecs[3]  = mk(1, 6'b000001, 8'd0,   8'd0, 8'd0,  8'd0, 8'd0, 8'd0, 8, 1'b0, 8'h00, 2'd1, 0);
    vecs[4]  = mk(1, 6'b000001, 8'd3,   8'd0, 8'd0,  8'd0, 8'd0, 8'd0, 8, 1'b0, 8'h00, 2'd1, 0);
    vecs[5]  = mk(5, 6'b000000, 8'd1,   8'd2, 8'd3,  8'd4, 8'd5, 8'd0, 4, 1'b0, 8'h00, 2'd2, 4);
    vecs[6]  = mk(4, 6'b001100, 8'hFD,  8'd4, 8'd2,  8'd3, 8'd0, 8'd0, 8, 1'b1, 8'hF4, 2'd0, 0);
    vecs[8]  = mk(4, 6'b001100, 8'd6,   8'd7, 8'hFC, 8'hFF, 8'd0, 8'd0, 8, 1'b1, 8'h0D, 2'd0, 0);
    vecs[9]  = mk(2, 6'b000010, 8'd1,   8'd0, 8'd0,  8'd0, 8'd0, 8'd0, 8, 1'b0, 8'h00, 2'd1, 0);
    vecs[11] = mk(6, 6'b111000, 8'd2,   8'd3, 8'd4,  8'd2, 8'd0, 8'd3, 8, 1'b1, 8'h0E, 2'd0, 0);
    vecs[12] = mk(4, 6'b001100, 8'd10,  8'd3, 8'd1,  8'd3, 8'd0, 8'd0, 8, 1'b1, 8'h07, 2'd0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_tok_ready", tok_ready, 1'b0);
    chk("rst_strobes", {stk_push, stk_pop}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", dbg_state, ST_IDLE);
    chk("reset_res_valid", res_valid, 1'b0);
    chk("reset_res_data", res_data, 8'h00);
    chk("reset_err", {err, err_code}, 3'b000);
    chk("reset_tok_ready", tok_ready, 1'b1);

    // Table of token sequences.
    for (int k = 0; k < 13; k++) run_vec(k, vecs[k]);

    // 3 4 + = with push/pop scoreboard and operator latency.
    depth = 8;
    do_reset();
    exp_q = '{8'd3, 8'd4, 8'd7};
    exp_pop_q = '{8'd4, 8'd3, 8'd7};
    chk_sb = 1'b1;
    send(1'b0, 8'd3, ok);
    send(1'b0, 8'd4, ok);
    send(1'b1, 8'd0, ok);
    repeat (3) @(negedge clk);
    chk("op_lat_no_push_yet", dbg_state, 4'd4);
    @(negedge clk);
    chk("op_lat_push_cycle5", stk_push, 1'b1);
    send(1'b1, 8'd3, ok);
    wait_outcome();
    chk("sb_res_data", res_data, 8'h07);
    consume();
    chk("sb_push_queue_drained", exp_q.size(), 0);
    chk("sb_pop_queue_drained", exp_pop_q.size(), 0);
    chk_sb = 1'b0;

    // 9 = with res_ready held low for three cycles.
    do_reset();
    send(1'b0, 8'd9, ok);
    @(negedge clk);
    chk("opnd_lat_busy", tok_ready, 1'b0);
    @(negedge clk);
    chk("opnd_lat_ready", tok_ready, 1'b1);
    send(1'b1, 8'd3, ok);
    @(negedge clk);
    chk("eq_pop_next_cycle", {stk_pop, res_valid}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_res_valid", i), res_valid, 1'b1);
      chk($sformatf("hold%0d_res_data", i), res_data, 8'd9);
      chk($sformatf("hold%0d_tok_ready", i), tok_ready, 1'b0);
      if (i == 3) res_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("after_hs_res_valid", res_valid, 1'b0);
    chk("after_hs_tok_ready", tok_ready, 1'b1);

    // Underflow is sticky until reset.
    do_reset();
    pop_seen = 0;
    send(1'b1, 8'd0, ok);
    repeat (6) @(negedge clk);
    chk("uf_pop_never", pop_seen, 0);
    chk("uf_err", {err, err_code}, 3'b101);
    chk("uf_tok_ready_low", tok_ready, 1'b0);
    do_reset();
    @(negedge clk);
    chk("uf_cleared_err", {err, err_code}, 3'b000);
    chk("uf_cleared_ready", tok_ready, 1'b1);

    // Reset asserted during EXEC.
    do_reset();
    send(1'b0, 8'd3, ok);
    send(1'b0, 8'd4, ok);
    send(1'b1, 8'd0, ok);
    repeat (3) @(negedge clk);
    chk("midrst_in_exec", dbg_state, ST_EXEC);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs_quiet", {tok_ready, stk_push, stk_pop}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state_idle", dbg_state, ST_IDLE);
    chk("midrst_outputs", {res_valid, err, err_code, res_data}, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
